// File: rtl/s1d_cmd_pkg.sv
// rtl/s1d_cmd_pkg.sv - S1D13700 command opcodes, parameter table and decoder state type.
package s1d_cmd_pkg;

   localparam logic [7:0] CMD_SYSSET    = 8'h40;
   localparam logic [7:0] CMD_SCROLL    = 8'h44;
   localparam logic [7:0] CMD_HDOTSCR   = 8'h5A;
   localparam logic [7:0] CMD_OVLAY     = 8'h5B;
   localparam logic [7:0] CMD_DISPOFF   = 8'h58;
   localparam logic [7:0] CMD_DISPON    = 8'h59;
   localparam logic [7:0] CMD_CSRFORM   = 8'h5D;
   localparam logic [7:0] CMD_CGRAMADR  = 8'h5C;
   localparam logic [7:0] CMD_CSRW      = 8'h46;
   localparam logic [7:0] CMD_GRAYSCALE = 8'h60;
   localparam logic [7:0] CMD_SLEEPIN   = 8'h53;
   localparam logic [7:0] CMD_MWRITE    = 8'h42;
   // 0x4C..0x4F: low two bits carry the cursor direction
   localparam logic [5:0] CMD_CSRDIR_HI = 6'b010011;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PARAM = 2'd1,
      ST_MWR   = 2'd2
   } dec_state_e;

   typedef struct packed {
      logic             has_param;
      logic [4:0]       base;
      logic [CNT_W-1:0] limit;
   } param_info_t;

   function automatic param_info_t param_info(input logic [7:0] cmd);
      param_info_t info;
      info           = '0;
      info.has_param = 1'b1;
      case (cmd)
         CMD_SYSSET:               begin info.base = 5'h00; info.limit = 4'd8;  end
         CMD_SCROLL:               begin info.base = 5'h08; info.limit = 4'd10; end
         CMD_HDOTSCR:              begin info.base = 5'h12; info.limit = 4'd1;  end
         CMD_OVLAY:                begin info.base = 5'h13; info.limit = 4'd1;  end
         CMD_DISPOFF, CMD_DISPON:  begin info.base = 5'h14; info.limit = 4'd1;  end
         CMD_CSRFORM:              begin info.base = 5'h15; info.limit = 4'd2;  end
         CMD_CGRAMADR:             begin info.base = 5'h17; info.limit = 4'd2;  end
         CMD_CSRW:                 begin info.base = 5'h19; info.limit = 4'd2;  end
         CMD_GRAYSCALE:            begin info.base = 5'h1B; info.limit = 4'd1;  end
         default:                  info.has_param = 1'b0;
      endcase
      return info;
   endfunction

endpackage

// File: rtl/s1d_bus_sync.sv
// rtl/s1d_bus_sync.sv - host write strobe synchroniser, data capture and release-edge event.
module s1d_bus_sync #(
   parameter int SYNC_STG = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce_x,
   input  logic       a0,
   input  logic       wr_x,
   input  logic [7:0] din,
   output logic       wr_evt,
   output logic       cap_a0,
   output logic [7:0] cap_dat
);

   logic [SYNC_STG-1:0] sync_q, sync_d;
   logic                act_prev_q, act_prev_d;
   logic                wr_evt_q, wr_evt_d;
   logic                cap_a0_q, cap_a0_d;
   logic [7:0]          cap_dat_q, cap_dat_d;
   logic                act;

   assign act = sync_q[SYNC_STG-1];

   always_comb begin
      sync_d     = {sync_q[SYNC_STG-2:0], ~ce_x & ~wr_x};
      act_prev_d = act;
      // Event on strobe release, registered so capture has settled before decode
      wr_evt_d   = act_prev_q & ~act;
      cap_a0_d   = act ? a0  : cap_a0_q;
      cap_dat_d  = act ? din : cap_dat_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         act_prev_q <= 1'b0;
         wr_evt_q   <= 1'b0;
         cap_a0_q   <= 1'b0;
         cap_dat_q  <= 8'h00;
      end else begin
         sync_q     <= sync_d;
         act_prev_q <= act_prev_d;
         wr_evt_q   <= wr_evt_d;
         cap_a0_q   <= cap_a0_d;
         cap_dat_q  <= cap_dat_d;
      end
   end

   assign wr_evt  = wr_evt_q;
   assign cap_a0  = cap_a0_q;
   assign cap_dat = cap_dat_q;

endmodule

// File: rtl/s1d_host_cmd_dec.sv
// rtl/s1d_host_cmd_dec.sv - S1D13700 host command/parameter decoder producing register and memory write strobes.
module s1d_host_cmd_dec #(
   parameter int SYNC_STG = 2,
   parameter int RADDR_W  = 5
) (
   input  logic               P_MCLKI,
   input  logic               P_RST_X,
   input  logic               ce_x,
   input  logic               a0,
   input  logic               wr_x,
   input  logic [7:0]         din,
   output logic               reg_we,
   output logic [RADDR_W-1:0] reg_addr,
   output logic [7:0]         reg_wdata,
   output logic               mem_we,
   output logic [7:0]         mem_wdata,
   output logic               mem_start,
   output logic               disp_on,
   output logic               sleep,
   output logic [1:0]         csr_dir,
   output logic               busy
);

   import s1d_cmd_pkg::*;

   logic        wr_evt, cap_a0;
   logic [7:0]  cap_dat;
   param_info_t info;

   dec_state_e         state_q, state_d;
   logic [RADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]   lim_q, lim_d, cnt_q, cnt_d;
   logic               reg_we_q, reg_we_d, mem_we_q, mem_we_d, mem_start_q, mem_start_d;
   logic [RADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]         reg_wdata_q, reg_wdata_d, mem_wdata_q, mem_wdata_d;
   logic               disp_on_q, disp_on_d, sleep_q, sleep_d;
   logic [1:0]         csr_dir_q, csr_dir_d;

   s1d_bus_sync #(.SYNC_STG(SYNC_STG)) u_sync (
      .clk     (P_MCLKI),
      .rst_n   (P_RST_X),
      .ce_x    (ce_x),
      .a0      (a0),
      .wr_x    (wr_x),
      .din     (din),
      .wr_evt  (wr_evt),
      .cap_a0  (cap_a0),
      .cap_dat (cap_dat)
   );

   assign info = param_info(cap_dat);

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      lim_d       = lim_q;
      cnt_d       = cnt_q;
      reg_we_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_start_d = 1'b0;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      mem_wdata_d = mem_wdata_q;
      disp_on_d   = disp_on_q;
      sleep_d     = sleep_q;
      csr_dir_d   = csr_dir_q;
      if (wr_evt) begin
         if (cap_a0) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            if (info.has_param) begin
               state_d = ST_PARAM;
               base_d  = RADDR_W'(info.base);
               lim_d   = info.limit;
            end
            if (cap_dat == CMD_SYSSET)                 sleep_d   = 1'b0;
            if (cap_dat == CMD_SLEEPIN)                sleep_d   = 1'b1;
            if (cap_dat[7:1] == CMD_DISPON[7:1])       disp_on_d = cap_dat[0];
            if (cap_dat[7:2] == CMD_CSRDIR_HI)         csr_dir_d = cap_dat[1:0];
            if (cap_dat == CMD_MWRITE) begin
               state_d     = ST_MWR;
               mem_start_d = 1'b1;
            end
         end else begin
            case (state_q)
               ST_PARAM: begin
                  // Excess parameters are dropped; count holds at the limit
                  if (cnt_q < lim_q) begin
                     reg_we_d    = 1'b1;
                     reg_addr_d  = base_q + RADDR_W'(cnt_q);
                     reg_wdata_d = cap_dat;
                     cnt_d       = cnt_q + 1'b1;
                  end
               end
               ST_MWR: begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = cap_dat;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge P_MCLKI or negedge P_RST_X) begin
      if (!P_RST_X) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         lim_q       <= '0;
         cnt_q       <= '0;
         reg_we_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_start_q <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= 8'h00;
         mem_wdata_q <= 8'h00;
         disp_on_q   <= 1'b0;
         sleep_q     <= 1'b0;
         csr_dir_q   <= 2'b00;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         lim_q       <= lim_d;
         cnt_q       <= cnt_d;
         reg_we_q    <= reg_we_d;
         mem_we_q    <= mem_we_d;
         mem_start_q <= mem_start_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         mem_wdata_q <= mem_wdata_d;
         disp_on_q   <= disp_on_d;
         sleep_q     <= sleep_d;
         csr_dir_q   <= csr_dir_d;
      end
   end

   assign reg_we    = reg_we_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_start = mem_start_q;
   assign disp_on   = disp_on_q;
   assign sleep     = sleep_q;
   assign csr_dir   = csr_dir_q;
   assign busy      = wr_evt;

endmodule

// File: tb/tb_s1d_host_cmd_dec.sv
// tb/tb_s1d_host_cmd_dec.sv - randomized self-checking bench for s1d_host_cmd_dec against a command-table model.
module tb_s1d_host_cmd_dec;

   localparam int SYNC_STG = 2;
   localparam int RADDR_W  = 5;

   logic               clk = 1'b0;
   logic               rst_x;
   logic               ce_x, a0, wr_x;
   logic [7:0]         din;
   logic               reg_we, mem_we, mem_start, disp_on, sleep, busy;
   logic [RADDR_W-1:0] reg_addr;
   logic [7:0]         reg_wdata, mem_wdata;
   logic [1:0]         csr_dir;

   int n_chk = 0;
   int n_err = 0;

   int rq_addr[$];
   int rq_data[$];
   int mq[$];
   int start_cnt = 0;
   int overlap   = 0;

   // Model state: 0 idle, 1 collecting parameters, 2 memory write
   int m_st, m_base, m_lim, m_cnt;
   bit m_disp, m_sleep;
   bit [1:0] m_dir;

   logic [7:0] cmd_tab [16] = '{8'h40, 8'h44, 8'h5A, 8'h5B, 8'h58, 8'h59, 8'h5D, 8'h5C,
                                8'h46, 8'h60, 8'h4C, 8'h4D, 8'h4E, 8'h4F, 8'h53, 8'h42};
   logic [7:0] sys_par [8]  = '{8'h30, 8'h87, 8'h07, 8'h27, 8'h48, 8'hEF, 8'h40, 8'h00};

   always #5 clk = ~clk;

   s1d_host_cmd_dec #(.SYNC_STG(SYNC_STG), .RADDR_W(RADDR_W)) dut (
      .P_MCLKI   (clk),
      .P_RST_X   (rst_x),
      .ce_x      (ce_x),
      .a0        (a0),
      .wr_x      (wr_x),
      .din       (din),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_start (mem_start),
      .disp_on   (disp_on),
      .sleep     (sleep),
      .csr_dir   (csr_dir),
      .busy      (busy)
   );

   always @(negedge clk) begin
      if (reg_we) begin
         rq_addr.push_back(int'(reg_addr));
         rq_data.push_back(int'(reg_wdata));
      end
      if (mem_we) mq.push_back(int'(mem_wdata));
      if (mem_start) start_cnt++;
      if (reg_we && mem_we) overlap++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_base = 0; m_lim = 0; m_cnt = 0;
      m_disp = 1'b0; m_sleep = 1'b0; m_dir = 2'b00;
   endtask

   task automatic model(input bit a, input logic [7:0] d,
                        output int rv, output int ra, output int mv, output int st);
      rv = 0; ra = 0; mv = 0; st = 0;
      if (a) begin
         m_cnt = 0;
         m_st  = 0;
         case (d)
            8'h40: begin m_st = 1; m_base = 'h00; m_lim = 8;  m_sleep = 1'b0; end
            8'h44: begin m_st = 1; m_base = 'h08; m_lim = 10; end
            8'h5A: begin m_st = 1; m_base = 'h12; m_lim = 1;  end
            8'h5B: begin m_st = 1; m_base = 'h13; m_lim = 1;  end
            8'h58, 8'h59: begin m_st = 1; m_base = 'h14; m_lim = 1; m_disp = d[0]; end
            8'h5D: begin m_st = 1; m_base = 'h15; m_lim = 2;  end
            8'h5C: begin m_st = 1; m_base = 'h17; m_lim = 2;  end
            8'h46: begin m_st = 1; m_base = 'h19; m_lim = 2;  end
            8'h60: begin m_st = 1; m_base = 'h1B; m_lim = 1;  end
            8'h4C, 8'h4D, 8'h4E, 8'h4F: m_dir = d[1:0];
            8'h53: m_sleep = 1'b1;
            8'h42: begin m_st = 2; st = 1; end
            default: ;
         endcase
      end else if (m_st == 1) begin
         if (m_cnt < m_lim) begin
            rv = 1;
            ra = m_base + m_cnt;
            m_cnt++;
         end
      end else if (m_st == 2) begin
         mv = 1;
      end
   endtask

   task automatic host_wr(input bit ce_en, input bit a, input logic [7:0] d);
      int er_v, er_a, em_v, e_st, lat;
      logic busy_seen, busy_after;
      er_v = 0; er_a = 0; em_v = 0; e_st = 0; lat = 0;
      busy_seen = 1'b0; busy_after = 1'b0;
      if (ce_en) model(a, d, er_v, er_a, em_v, e_st);
      rq_addr.delete(); rq_data.delete(); mq.delete(); start_cnt = 0;
      @(posedge clk); #1;
      a0 = a; din = d; ce_x = ~ce_en; wr_x = 1'b0;
      repeat (3) @(posedge clk);
      #1; wr_x = 1'b1; ce_x = 1'b1;
      for (int n = 1; n <= SYNC_STG + 6; n++) begin
         @(posedge clk); #1;
         if (lat == 0 && (reg_we || mem_we || mem_start)) lat = n;
         if (n == SYNC_STG + 1) busy_seen  = busy;
         if (n == SYNC_STG + 2) busy_after = busy;
      end
      if (er_v != 0 || em_v != 0 || e_st != 0) chk("latency", 32'(lat), 32'(SYNC_STG + 2));
      chk("busy_evt", 32'(busy_seen), 32'(ce_en));
      chk("busy_done", 32'(busy_after), 32'd0);
      chk("n_reg_we", 32'(rq_addr.size()), 32'(er_v));
      if (er_v != 0 && rq_addr.size() == 1) begin
         chk("reg_addr", 32'(rq_addr[0]), 32'(er_a));
         chk("reg_wdata", 32'(rq_data[0]), 32'(d));
      end
      chk("n_mem_we", 32'(mq.size()), 32'(em_v));
      if (em_v != 0 && mq.size() == 1) chk("mem_wdata", 32'(mq[0]), 32'(d));
      chk("mem_start", 32'(start_cnt), 32'(e_st));
      chk("disp_on", 32'(disp_on), 32'(m_disp));
      chk("sleep", 32'(sleep), 32'(m_sleep));
      chk("csr_dir", 32'(csr_dir), 32'(m_dir));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_reg_we"}, 32'(reg_we), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_start"}, 32'(mem_start), 32'd0);
      chk({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
      chk({tag, "_reg_wdata"}, 32'(reg_wdata), 32'd0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, "_disp_on"}, 32'(disp_on), 32'd0);
      chk({tag, "_sleep"}, 32'(sleep), 32'd0);
      chk({tag, "_csr_dir"}, 32'(csr_dir), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit a;
      logic [7:0] d;
      rst_x = 1'b0; ce_x = 1'b1; wr_x = 1'b1; a0 = 1'b0; din = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #1; chk_reset_vals("rst_in");
      rst_x = 1'b1;
      repeat (2) @(posedge clk);
      #1; chk_reset_vals("rst_out");

      host_wr(1'b1, 1'b1, 8'h40);
      for (int i = 0; i < 8; i++) host_wr(1'b1, 1'b0, sys_par[i]);

      host_wr(1'b1, 1'b1, 8'h44);
      host_wr(1'b1, 1'b0, 8'h22);
      host_wr(1'b1, 1'b0, 8'h33);
      host_wr(1'b1, 1'b0, 8'h44);
      host_wr(1'b1, 1'b1, 8'h40);
      host_wr(1'b1, 1'b0, 8'h5E);

      host_wr(1'b1, 1'b1, 8'h5D);
      host_wr(1'b1, 1'b0, 8'h11);
      host_wr(1'b1, 1'b0, 8'h22);
      host_wr(1'b1, 1'b0, 8'h33);
      host_wr(1'b1, 1'b0, 8'h44);

      host_wr(1'b1, 1'b1, 8'h42);
      host_wr(1'b1, 1'b0, 8'hAA);
      host_wr(1'b1, 1'b0, 8'h55);
      host_wr(1'b1, 1'b0, 8'h01);

      host_wr(1'b1, 1'b1, 8'h59);
      host_wr(1'b1, 1'b0, 8'h14);
      host_wr(1'b1, 1'b1, 8'h4E);
      host_wr(1'b1, 1'b1, 8'h53);

      host_wr(1'b0, 1'b1, 8'h42);
      host_wr(1'b0, 1'b0, 8'h77);

      // Reset lands while the third SYSTEM SET parameter strobe is low
      host_wr(1'b1, 1'b1, 8'h40);
      host_wr(1'b1, 1'b0, sys_par[0]);
      host_wr(1'b1, 1'b0, sys_par[1]);
      @(posedge clk); #1;
      a0 = 1'b0; din = sys_par[2]; ce_x = 1'b0; wr_x = 1'b0;
      repeat (3) @(posedge clk);
      #1; rst_x = 1'b0;
      rq_addr.delete(); rq_data.delete(); mq.delete(); start_cnt = 0;
      repeat (2) @(posedge clk);
      #1; wr_x = 1'b1; ce_x = 1'b1;
      repeat (2) @(posedge clk);
      #1; rst_x = 1'b1;
      model_reset();
      repeat (SYNC_STG + 6) @(posedge clk);
      #1;
      chk("rst_mid_reg_we", 32'(rq_addr.size()), 32'd0);
      chk("rst_mid_mem_we", 32'(mq.size()), 32'd0);
      chk("rst_mid_start", 32'(start_cnt), 32'd0);
      chk_reset_vals("rst_mid");
      host_wr(1'b1, 1'b0, 8'h55);

      for (int i = 0; i < 250; i++) begin
         a = ($urandom_range(0, 3) == 0);
         if (a) d = ($urandom_range(0, 7) == 0) ? 8'($urandom) : cmd_tab[$urandom_range(0, 15)];
         else   d = 8'($urandom);
         host_wr(($urandom_range(0, 15) != 0), a, d);
      end

      chk("strobe_exclusive", 32'(overlap), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
